// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of the FIFO write port between producers A and B,
// with a fixed-length FIFO clear sequencer and saturating per-producer word counters.
module fifo_wr_arbiter #(
    parameter int DW         = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic          CLOCK,
    input  logic          RESET_N,
    input  logic          REQ_A,
    input  logic [DW-1:0] DATA_A,
    output logic          ACK_A,
    input  logic          REQ_B,
    input  logic [DW-1:0] DATA_B,
    output logic          ACK_B,
    input  logic          FLUSH,
    input  logic          F_FULL_N,
    output logic          WRITE,
    output logic [DW-1:0] DATA_IN,
    output logic          CLEAR_N,
    output logic          BUSY,
    output logic [7:0]    CNT_A,
    output logic [7:0]    CNT_B
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_CLR} state_t;
    typedef enum logic {PROD_A, PROD_B} prod_t;

    localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);

    state_t        state_q, state_d;
    prod_t         last_q, last_d;
    logic [3:0]    clr_cnt_q, clr_cnt_d;
    logic          write_q, write_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic [DW-1:0] data_in_q, data_in_d;
    logic          clear_n_q, clear_n_d;
    logic          busy_q, busy_d;
    logic [7:0]    cnt_a_q, cnt_a_d;
    logic [7:0]    cnt_b_q, cnt_b_d;

    logic idle_ok, gnt_a, gnt_b;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // FLUSH outranks any grant; the last winner yields on a tie
    assign idle_ok = (state_q == ST_IDLE) && !FLUSH && F_FULL_N;
    assign gnt_a   = idle_ok && REQ_A && (!REQ_B || last_q == PROD_B);
    assign gnt_b   = idle_ok && REQ_B && (!REQ_A || last_q == PROD_A);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            last_q    <= PROD_B;
            clr_cnt_q <= '0;
            write_q   <= 1'b0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            data_in_q <= '0;
            clear_n_q <= 1'b1;
            busy_q    <= 1'b0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            clr_cnt_q <= clr_cnt_d;
            write_q   <= write_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            data_in_q <= data_in_d;
            clear_n_q <= clear_n_d;
            busy_q    <= busy_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (FLUSH)               state_d = ST_CLR;
                else if (gnt_a || gnt_b) state_d = ST_WR;
            end
            ST_WR:   state_d = ST_IDLE;
            ST_CLR:  if (clr_cnt_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so each _d value is what the port shows after the edge
    always_comb begin
        last_d    = last_q;
        clr_cnt_d = clr_cnt_q;
        write_d   = 1'b0;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        data_in_d = data_in_q;
        clear_n_d = 1'b1;
        busy_d    = 1'b0;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (FLUSH) begin
                    clear_n_d = 1'b0;
                    busy_d    = 1'b1;
                    clr_cnt_d = CLR_LOAD;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                end else if (gnt_a) begin
                    write_d   = 1'b1;
                    ack_a_d   = 1'b1;
                    busy_d    = 1'b1;
                    data_in_d = DATA_A;
                    cnt_a_d   = sat_inc(cnt_a_q);
                    last_d    = PROD_A;
                end else if (gnt_b) begin
                    write_d   = 1'b1;
                    ack_b_d   = 1'b1;
                    busy_d    = 1'b1;
                    data_in_d = DATA_B;
                    cnt_b_d   = sat_inc(cnt_b_q);
                    last_d    = PROD_B;
                end
            end
            ST_WR: begin
            end
            ST_CLR: begin
                if (clr_cnt_q != '0) begin
                    clear_n_d = 1'b0;
                    busy_d    = 1'b1;
                    clr_cnt_d = clr_cnt_q - 4'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign WRITE   = write_q;
    assign ACK_A   = ack_a_q;
    assign ACK_B   = ack_b_q;
    assign DATA_IN = data_in_q;
    assign CLEAR_N = clear_n_q;
    assign BUSY    = busy_q;
    assign CNT_A   = cnt_a_q;
    assign CNT_B   = cnt_b_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a cycle-level reference model predicts every
// cycle's outputs and each FIFO write; a separate monitor pops and compares.
module tb_fifo_wr_arbiter;

    localparam int DW         = 8;
    localparam int CLR_CYCLES = 2;

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic          REQ_A, REQ_B, FLUSH, F_FULL_N;
    logic [DW-1:0] DATA_A, DATA_B;
    logic          ACK_A, ACK_B, WRITE, CLEAR_N, BUSY;
    logic [DW-1:0] DATA_IN;
    logic [7:0]    CNT_A, CNT_B;

    fifo_wr_arbiter #(.DW(DW), .CLR_CYCLES(CLR_CYCLES)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .REQ_A(REQ_A), .DATA_A(DATA_A), .ACK_A(ACK_A),
        .REQ_B(REQ_B), .DATA_B(DATA_B), .ACK_B(ACK_B),
        .FLUSH(FLUSH), .F_FULL_N(F_FULL_N),
        .WRITE(WRITE), .DATA_IN(DATA_IN), .CLEAR_N(CLEAR_N),
        .BUSY(BUSY), .CNT_A(CNT_A), .CNT_B(CNT_B)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        bit write, ack_a, ack_b, clear_n, busy;
        int cnt_a, cnt_b;
    } status_t;

    typedef struct {
        bit          from_a;
        logic [7:0]  data;
    } wr_t;

    status_t exp_q[$];
    wr_t     wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    // stimulus knobs (percent probabilities)
    int p_a = 0, p_b = 0, p_full = 0, p_flush = 0;
    int flush_mode = 0;  // 0 low, 1 held high, 2 random

    // reference model: the outputs expected after the coming edge
    bit m_write, m_ack_a, m_ack_b, m_clear_n, m_busy, m_last_b;
    int m_cnt_a, m_cnt_b, m_clr_left;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_write = 0; m_ack_a = 0; m_ack_b = 0; m_clear_n = 1; m_busy = 0;
        m_last_b = 1; m_cnt_a = 0; m_cnt_b = 0; m_clr_left = 0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs now on the pins
    task automatic model_edge();
        bit  take_a;
        wr_t w;
        if (m_write) begin
            m_write = 0; m_ack_a = 0; m_ack_b = 0; m_busy = 0;
        end else if (!m_clear_n) begin
            if (m_clr_left > 0) m_clr_left--;
            else begin
                m_clear_n = 1; m_busy = 0;
            end
        end else if (FLUSH) begin
            m_clear_n = 0; m_busy = 1; m_cnt_a = 0; m_cnt_b = 0;
            m_clr_left = CLR_CYCLES - 1;
        end else if (F_FULL_N && (REQ_A || REQ_B)) begin
            take_a   = REQ_A && (!REQ_B || m_last_b);
            m_last_b = !take_a;
            m_write  = 1; m_busy = 1;
            m_ack_a  = take_a; m_ack_b = !take_a;
            if (take_a) m_cnt_a = (m_cnt_a >= 255) ? 255 : m_cnt_a + 1;
            else        m_cnt_b = (m_cnt_b >= 255) ? 255 : m_cnt_b + 1;
            w.from_a = take_a;
            w.data   = take_a ? DATA_A : DATA_B;
            wr_q.push_back(w);
        end
    endtask

    // One cycle: drive inputs at the falling edge, predict, queue the expectation
    task automatic step();
        status_t s;
        @(negedge CLOCK);
        if (REQ_A && ACK_A) REQ_A = 0;
        if (REQ_B && ACK_B) REQ_B = 0;
        if (!REQ_A && ($urandom % 100) < p_a) begin REQ_A = 1; DATA_A = 8'($urandom); end
        if (!REQ_B && ($urandom % 100) < p_b) begin REQ_B = 1; DATA_B = 8'($urandom); end
        F_FULL_N = (($urandom % 100) >= p_full);
        case (flush_mode)
            0:       FLUSH = 0;
            1:       FLUSH = 1;
            default: FLUSH = (($urandom % 100) < p_flush);
        endcase
        model_edge();
        s.write = m_write; s.ack_a = m_ack_a; s.ack_b = m_ack_b;
        s.clear_n = m_clear_n; s.busy = m_busy; s.cnt_a = m_cnt_a; s.cnt_b = m_cnt_b;
        exp_q.push_back(s);
        mon_en = 1;
    endtask

    // Asynchronous reset between edges; outputs must take reset values with no clock
    task automatic do_reset(input string tag);
        @(negedge CLOCK);
        mon_en = 0;
        chk({tag, "_wq_drained"}, wr_q.size(), 0);
        #2;
        RESET_N = 0;
        REQ_A = 0; REQ_B = 0; FLUSH = 0; F_FULL_N = 1; DATA_A = '0; DATA_B = '0;
        #1;
        chk({tag, "_write"},   WRITE,   0);
        chk({tag, "_ack_a"},   ACK_A,   0);
        chk({tag, "_ack_b"},   ACK_B,   0);
        chk({tag, "_data_in"}, DATA_IN, 0);
        chk({tag, "_clear_n"}, CLEAR_N, 1);
        chk({tag, "_busy"},    BUSY,    0);
        chk({tag, "_cnt_a"},   CNT_A,   0);
        chk({tag, "_cnt_b"},   CNT_B,   0);
        model_reset();
        exp_q.delete();
        wr_q.delete();
        repeat (2) @(negedge CLOCK);
        RESET_N = 1;
    endtask

    initial begin : monitor
        status_t s;
        wr_t     w;
        forever begin
            @(posedge CLOCK);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("status_queue_underflow", 0, 1);
                end else begin
                    s = exp_q.pop_front();
                    chk("write",   WRITE,   s.write);
                    chk("ack_a",   ACK_A,   s.ack_a);
                    chk("ack_b",   ACK_B,   s.ack_b);
                    chk("clear_n", CLEAR_N, s.clear_n);
                    chk("busy",    BUSY,    s.busy);
                    chk("cnt_a",   CNT_A,   s.cnt_a);
                    chk("cnt_b",   CNT_B,   s.cnt_b);
                end
                if (WRITE === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        w = wr_q.pop_front();
                        chk("wr_data",   DATA_IN, w.data);
                        chk("wr_from_a", ACK_A,   w.from_a);
                        chk("wr_from_b", ACK_B,   !w.from_a);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        RESET_N = 1; REQ_A = 0; REQ_B = 0; FLUSH = 0; F_FULL_N = 1;
        DATA_A = '0; DATA_B = '0;
        model_reset();
        #2;
        do_reset("rst_init");

        // Both producers always pending: grants alternate A,B,A,B
        p_a = 100; p_b = 100; p_full = 0; flush_mode = 0;
        repeat (8) step();

        // FIFO full holds off a pending B, which then goes through
        do_reset("rst_bp");
        p_a = 0; p_b = 100; p_full = 100;
        repeat (5) step();
        p_full = 0; p_b = 0;
        repeat (4) step();

        // FLUSH raised while a write is in flight; A keeps requesting throughout
        do_reset("rst_fl");
        p_a = 100; p_b = 0;
        step();
        flush_mode = 1;
        repeat (2) step();
        flush_mode = 0;
        repeat (8) step();

        // Randomised traffic with backpressure and occasional flushes
        do_reset("rst_rand");
        p_a = 40; p_b = 45; p_full = 30; flush_mode = 2; p_flush = 4;
        repeat (2000) step();
        flush_mode = 0; p_a = 0; p_b = 0; p_full = 0;
        repeat (8) step();

        // 270 writes from A: counter saturates at 255 and stays there
        do_reset("rst_sat");
        p_a = 100; p_b = 0;
        repeat (540) step();
        @(posedge CLOCK); #2;
        chk("sat_cnt_a", CNT_A, 255);
        chk("sat_cnt_b", CNT_B, 0);
        repeat (4) step();
        @(posedge CLOCK); #2;
        chk("sat_cnt_a_hold", CNT_A, 255);

        // Reset aborting a write with nonzero counters
        do_reset("rst_pre_wr");
        p_a = 100; p_b = 0;
        repeat (5) step();
        do_reset("rst_mid_wr");

        // Reset aborting a clear sequence
        p_a = 0;
        flush_mode = 1;
        step();
        flush_mode = 0;
        do_reset("rst_mid_clr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
